// File: rtl/tone_recorder_if.sv
`default_nettype none
// ============================================================================
//  Module : tone_recorder_if
//  Brief  : Control, live-tone and playback signals of the tone recorder.
//  Rev    : 1.0 - initial release
// ============================================================================
interface tone_recorder_if #(
    parameter int TONE_W = 16,
    parameter int ADDR_W = 6
);
    logic              rec_start;
    logic              play_start;
    logic              stop;
    logic [TONE_W-1:0] live_tone;
    logic [TONE_W-1:0] rec_tone;
    logic [1:0]        state;
    logic [ADDR_W:0]   rec_len;
    logic              full;
    logic              play_done;

    modport master (
        output rec_start, play_start, stop, live_tone,
        input  rec_tone, state, rec_len, full, play_done
    );

    modport slave (
        input  rec_start, play_start, stop, live_tone,
        output rec_tone, state, rec_len, full, play_done
    );
endinterface
`default_nettype wire

// File: rtl/tone_recorder.sv
`default_nettype none
// ============================================================================
//  Module : tone_recorder
//  Brief  : Samples the live tone once per beat into a note buffer and replays
//           it at the same beat rate.
//  Rev    : 1.0 - initial release
// ============================================================================
module tone_recorder #(
    parameter int TONE_W      = 16,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int BEAT_PERIOD = 6000000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    tone_recorder_if.slave bus
);

    localparam int              c_BEAT_W    = (BEAT_PERIOD > 1) ? $clog2(BEAT_PERIOD) : 1;
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BEAT_PERIOD - 1);
    localparam logic [ADDR_W:0] c_DEPTH_M1  = (ADDR_W + 1)'(DEPTH - 1);

    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_RECORD = 2'b01;
    localparam logic [1:0] c_PLAY   = 2'b10;

    logic [1:0]          r_state;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_rec_len;
    logic                r_full;
    logic                r_play_done;
    logic [TONE_W-1:0]   r_rec_tone;
    logic [TONE_W-1:0]   r_mem [DEPTH];

    logic w_beat;
    logic w_last_note;
    logic w_rec_last;
    logic w_mem_we;

    assign w_beat      = (r_beat_cnt == c_BEAT_LAST);
    assign w_last_note = ({1'b0, r_rd_ptr} == (r_rec_len - 1'b1));
    assign w_rec_last  = (r_rec_len == c_DEPTH_M1);
    assign w_mem_we    = rst_n && (r_state == c_RECORD) && !bus.stop && w_beat;

    // Buffer content survives reset; rec_len alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= bus.live_tone;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_beat_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rec_len   <= '0;
            r_full      <= 1'b0;
            r_play_done <= 1'b0;
            r_rec_tone  <= '0;
        end else begin
            r_play_done <= 1'b0;
            r_rec_tone  <= (r_state == c_PLAY) ? r_mem[r_rd_ptr] : '0;

            case (r_state)
                c_IDLE: begin
                    r_beat_cnt <= '0;
                    if (bus.rec_start) begin
                        r_state   <= c_RECORD;
                        r_wr_ptr  <= '0;
                        r_rec_len <= '0;
                        r_full    <= 1'b0;
                    end else if (bus.play_start) begin
                        if (r_rec_len == '0) begin
                            r_play_done <= 1'b1;
                        end else begin
                            r_state  <= c_PLAY;
                            r_rd_ptr <= '0;
                        end
                    end
                end

                c_RECORD: begin
                    if (bus.stop) begin
                        r_state    <= c_IDLE;
                        r_beat_cnt <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= '0;
                        r_rec_len  <= r_rec_len + 1'b1;
                        // Pointer is held on the final write so it stays below DEPTH.
                        if (w_rec_last) begin
                            r_full  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end

                c_PLAY: begin
                    if (bus.stop) begin
                        r_state    <= c_IDLE;
                        r_beat_cnt <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= '0;
                        if (w_last_note) begin
                            r_state     <= c_IDLE;
                            r_play_done <= 1'b1;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= c_IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.rec_tone  = r_rec_tone;
    assign bus.state     = r_state;
    assign bus.rec_len   = r_rec_len;
    assign bus.full      = r_full;
    assign bus.play_done = r_play_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_recorder.sv
`default_nettype none
// ============================================================================
//  Module : tb_tone_recorder
//  Brief  : Directed and random stimulus against a note-list reference model.
//  Rev    : 1.0 - initial release
// ============================================================================
module tb_tone_recorder;

    localparam int TONE_W      = 16;
    localparam int DEPTH       = 4;
    localparam int ADDR_W      = 2;
    localparam int BEAT_PERIOD = 4;

    logic clk = 1'b0;
    logic rst_n;

    tone_recorder_if #(.TONE_W(TONE_W), .ADDR_W(ADDR_W)) bus ();

    tone_recorder #(
        .TONE_W     (TONE_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .BEAT_PERIOD(BEAT_PERIOD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: mode 0 idle / 1 record / 2 play, age = edges since entry,
    // notes = the recorded tone list.
    int              m_mode = 0;
    int              m_age  = 0;
    logic [TONE_W-1:0] m_notes[$];
    logic            m_full = 1'b0;
    logic            m_done = 1'b0;
    logic [TONE_W-1:0] m_tone = '0;

    task automatic model_edge(input bit rn, input bit rs, input bit ps, input bit sp,
                              input logic [TONE_W-1:0] lt);
        logic [TONE_W-1:0] nt;
        logic              nd;
        nt = '0;
        nd = 1'b0;
        if (!rn) begin
            m_mode = 0;
            m_age  = 0;
            m_notes.delete();
            m_full = 1'b0;
        end else begin
            if (m_mode == 2 && (m_age / BEAT_PERIOD) < m_notes.size())
                nt = m_notes[m_age / BEAT_PERIOD];
            case (m_mode)
                0: begin
                    if (rs) begin
                        m_mode = 1;
                        m_age  = 0;
                        m_notes.delete();
                        m_full = 1'b0;
                    end else if (ps) begin
                        if (m_notes.size() == 0) nd = 1'b1;
                        else begin
                            m_mode = 2;
                            m_age  = 0;
                        end
                    end
                end
                1: begin
                    if (sp) m_mode = 0;
                    else begin
                        m_age++;
                        if (m_age % BEAT_PERIOD == 0) begin
                            m_notes.push_back(lt);
                            if (m_notes.size() == DEPTH) begin
                                m_full = 1'b1;
                                m_mode = 0;
                            end
                        end
                    end
                end
                default: begin
                    if (sp) m_mode = 0;
                    else begin
                        m_age++;
                        if (m_age == m_notes.size() * BEAT_PERIOD) begin
                            m_mode = 0;
                            nd     = 1'b1;
                        end
                    end
                end
            endcase
        end
        m_tone = nt;
        m_done = nd;
    endtask

    task automatic tick(input bit rs, input bit ps, input bit sp,
                        input logic [TONE_W-1:0] lt, input bit rn);
        rst_n          = rn;
        bus.rec_start  = rs;
        bus.play_start = ps;
        bus.stop       = sp;
        bus.live_tone  = lt;
        @(posedge clk);
        model_edge(rn, rs, ps, sp, lt);
        #1;
        check_val("state",     32'(bus.state),     32'(m_mode));
        check_val("rec_tone",  32'(bus.rec_tone),  32'(m_tone));
        check_val("rec_len",   32'(bus.rec_len),   32'(m_notes.size()));
        check_val("full",      32'(bus.full),      32'(m_full));
        check_val("play_done", 32'(bus.play_done), 32'(m_done));
        bus.rec_start  = 1'b0;
        bus.play_start = 1'b0;
        bus.stop       = 1'b0;
    endtask

    logic [TONE_W-1:0] vals [3] = '{16'd30612, 16'd27273, 16'd22931};

    initial begin
        rst_n          = 1'b0;
        bus.rec_start  = 1'b0;
        bus.play_start = 1'b0;
        bus.stop       = 1'b0;
        bus.live_tone  = '0;

        tick(0, 0, 0, 16'd0, 0);
        tick(0, 0, 0, 16'd0, 0);
        check_val("reset_state", 32'(bus.state), 32'd0);

        // Three-note recording, then stop
        tick(1, 0, 0, 16'd0, 1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < BEAT_PERIOD; j++)
                tick(0, 0, 0, vals[i], 1);
        tick(0, 0, 1, 16'd0, 1);
        check_val("rec3_len",  32'(bus.rec_len), 32'd3);
        check_val("rec3_full", 32'(bus.full),    32'd0);

        // Playback of those notes
        tick(0, 1, 0, 16'd0, 1);
        tick(0, 0, 0, 16'd0, 1);
        check_val("play_first", 32'(bus.rec_tone), 32'd30612);
        for (int k = 2; k <= 12; k++) begin
            tick(0, 0, 0, 16'd0, 1);
            if (k == 5)  check_val("play_second", 32'(bus.rec_tone), 32'd27273);
            if (k == 12) check_val("play_last",   32'(bus.rec_tone), 32'd22931);
        end
        check_val("play_done_12", 32'(bus.play_done), 32'd1);
        tick(0, 0, 0, 16'd0, 1);
        check_val("tone_after_play", 32'(bus.rec_tone), 32'd0);

        // Fill the buffer without stop
        tick(1, 0, 0, 16'd0, 1);
        for (int k = 0; k < DEPTH * BEAT_PERIOD; k++) tick(0, 0, 0, 16'd45872, 1);
        check_val("fill_state", 32'(bus.state),   32'd0);
        check_val("fill_len",   32'(bus.rec_len), 32'd4);
        check_val("fill_full",  32'(bus.full),    32'd1);
        tick(1, 0, 0, 16'd0, 1);
        check_val("full_cleared", 32'(bus.full), 32'd0);
        tick(0, 0, 1, 16'd0, 1);

        // Empty playback after reset
        tick(0, 0, 0, 16'd0, 0);
        tick(0, 1, 0, 16'd0, 1);
        check_val("empty_done", 32'(bus.play_done), 32'd1);
        tick(0, 0, 0, 16'd0, 1);
        check_val("empty_done_drop", 32'(bus.play_done), 32'd0);

        // Reset in the middle of playback
        tick(1, 0, 0, 16'd0, 1);
        for (int k = 0; k < 2 * BEAT_PERIOD; k++) tick(0, 0, 0, 16'(1000 + k), 1);
        tick(0, 0, 1, 16'd0, 1);
        tick(0, 1, 0, 16'd0, 1);
        for (int k = 0; k < 5; k++) tick(0, 0, 0, 16'd0, 1);
        tick(0, 0, 0, 16'd0, 0);
        check_val("midplay_rst_len",  32'(bus.rec_len),  32'd0);
        check_val("midplay_rst_tone", 32'(bus.rec_tone), 32'd0);

        // Simultaneous controls
        tick(1, 1, 0, 16'd0, 1);
        check_val("rec_wins", 32'(bus.state), 32'd1);
        for (int k = 0; k < BEAT_PERIOD; k++) tick(0, 0, 0, 16'd777, 1);
        tick(1, 0, 1, 16'd0, 1);
        check_val("stop_wins_state", 32'(bus.state),   32'd0);
        check_val("stop_wins_len",   32'(bus.rec_len), 32'd1);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            tick(($urandom_range(15) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(63) == 0), 16'($urandom),
                 ($urandom_range(499) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
